// File: rtl/spr_nest_if.sv
// Interrupt-path bus between the pipeline and the nested SPR file:
// cause/PC inputs plus the SPR access port in, jisr/il/epc/mode feedback out.
interface spr_nest_if #(
  parameter int DATA_W  = 32,
  parameter int N_SPR   = 8,
  parameter int N_CAUSE = 23,
  parameter int N_EXT   = 8,
  parameter int DEPTH   = 2
) ();
  logic                         ue;
  logic [N_EXT-1:0]             ev_ext;
  logic [N_CAUSE-N_EXT-1:0]     ev_int;
  logic [DATA_W-1:0]            pc;
  logic [DATA_W-1:0]            next_pc;
  logic [DATA_W-1:0]            ea;
  logic                         eret;
  logic                         sprw;
  logic [$clog2(N_SPR)-1:0]     reg_sel;
  logic [DATA_W-1:0]            data_in;
  logic [DATA_W-1:0]            spr_out;
  logic                         jisr;
  logic [$clog2(N_CAUSE)-1:0]   il;
  logic [DATA_W-1:0]            sr;
  logic [DATA_W-1:0]            epc;
  logic                         mode;
  logic [$clog2(DEPTH+1)-1:0]   depth;
  logic                         stk_ovf;

  modport master (
    output ue, ev_ext, ev_int, pc, next_pc, ea, eret, sprw, reg_sel, data_in,
    input  spr_out, jisr, il, sr, epc, mode, depth, stk_ovf
  );

  modport slave (
    input  ue, ev_ext, ev_int, pc, next_pc, ea, eret, sprw, reg_sel, data_in,
    output spr_out, jisr, il, sr, epc, mode, depth, stk_ovf
  );
endinterface

// File: rtl/spr_nest.sv
// Special-purpose register file with on-chip cause collection and a
// DEPTH-entry nested save stack for {sr, epc, mode}.
module spr_nest #(
  parameter int                 DATA_W   = 32,
  parameter int                 N_SPR    = 8,
  parameter int                 N_CAUSE  = 23,
  parameter int                 N_EXT    = 8,
  parameter int                 DEPTH    = 2,
  parameter logic [N_CAUSE-1:0] RPT_MASK = '0
) (
  input  logic      clk,
  input  logic      rst_n,
  spr_nest_if.slave bus
);
  localparam int SEL_W = $clog2(N_SPR);
  localparam int IL_W  = $clog2(N_CAUSE);
  localparam int DW    = $clog2(DEPTH + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NI    = N_CAUSE - N_EXT;
  localparam int NS    = 1 << SEL_W;
  localparam int NSLOT = 1 << AW;

  localparam logic [SEL_W-1:0] IDX_SR    = SEL_W'(3'd0);
  localparam logic [SEL_W-1:0] IDX_ESR   = SEL_W'(3'd1);
  localparam logic [SEL_W-1:0] IDX_ECA   = SEL_W'(3'd2);
  localparam logic [SEL_W-1:0] IDX_EPC   = SEL_W'(3'd3);
  localparam logic [SEL_W-1:0] IDX_EDATA = SEL_W'(3'd4);
  localparam logic [SEL_W-1:0] IDX_MODE  = SEL_W'(3'd7);
  localparam logic [AW-1:0]    SLOT_LAST = AW'(DEPTH - 1);

  logic [DATA_W-1:0] spr_q   [NS];
  logic [DATA_W-1:0] spr_d   [NS];
  logic [DATA_W-1:0] ssr_q   [NSLOT];
  logic [DATA_W-1:0] ssr_d   [NSLOT];
  logic [DATA_W-1:0] sepc_q  [NSLOT];
  logic [DATA_W-1:0] sepc_d  [NSLOT];
  logic              smode_q [NSLOT];
  logic              smode_d [NSLOT];
  logic              mode_q, mode_d;
  logic [DW-1:0]     depth_q, depth_d;
  logic              ovf_q, ovf_d;
  logic [N_EXT-1:0]  pend_q, pend_d;

  logic [N_CAUSE-1:0] ca_s, mca_s;
  logic [IL_W-1:0]    il_s;
  logic               jisr_s;
  logic [N_EXT-1:0]   clr_s;
  logic [AW-1:0]      top_s, push_s;
  logic [DATA_W-1:0]  epc_sel_s, rd_s;

  // Cause collection, masking, priority encode and pending-latch update
  always_comb begin
    ca_s   = {bus.ev_int & {NI{bus.ue}}, pend_q};
    mca_s  = ca_s & {spr_q[IDX_SR][N_CAUSE-1:1], 1'b1};
    il_s   = '0;
    for (int i = N_CAUSE - 1; i >= 0; i--) begin
      il_s = mca_s[i] ? IL_W'(i) : il_s;
    end
    jisr_s = bus.ue & (|mca_s);
    // a line still high while being cleared re-enters through the OR
    clr_s  = (jisr_s && (il_s < IL_W'(N_EXT))) ? (N_EXT'(1'b1) << il_s) : '0;
    pend_d = (pend_q & ~clr_s) | bus.ev_ext;
    top_s  = (depth_q != '0) ? AW'(depth_q - DW'(1'b1)) : '0;
    push_s = AW'(depth_q);
    epc_sel_s = RPT_MASK[il_s] ? bus.pc : bus.next_pc;
  end

  // SPR read port
  always_comb begin
    rd_s = '0;
    if (int'(bus.reg_sel) < N_SPR) begin
      case (bus.reg_sel)
        IDX_ESR:  rd_s = ssr_q[top_s];
        IDX_EPC:  rd_s = sepc_q[top_s];
        IDX_MODE: rd_s = DATA_W'(mode_q);
        default:  rd_s = spr_q[bus.reg_sel];
      endcase
    end else begin
      rd_s = '0;
    end
  end

  // Edge action selection: jisr, then eret, then sprw
  always_comb begin
    spr_d   = spr_q;
    ssr_d   = ssr_q;
    sepc_d  = sepc_q;
    smode_d = smode_q;
    mode_d  = mode_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    if (jisr_s) begin
      if (depth_q < DW'(DEPTH)) begin
        ssr_d[push_s]   = spr_q[IDX_SR];
        sepc_d[push_s]  = epc_sel_s;
        smode_d[push_s] = mode_q;
        depth_d         = depth_q + DW'(1'b1);
      end else begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          ssr_d[i]   = ssr_q[i+1];
          sepc_d[i]  = sepc_q[i+1];
          smode_d[i] = smode_q[i+1];
        end
        ssr_d[SLOT_LAST]   = spr_q[IDX_SR];
        sepc_d[SLOT_LAST]  = epc_sel_s;
        smode_d[SLOT_LAST] = mode_q;
        ovf_d              = 1'b1;
      end
      spr_d[IDX_SR]    = '0;
      spr_d[IDX_ECA]   = DATA_W'(mca_s);
      spr_d[IDX_EDATA] = bus.ea;
      mode_d           = 1'b0;
    end else if (bus.ue && bus.eret) begin
      spr_d[IDX_SR] = ssr_q[top_s];
      mode_d        = smode_q[top_s];
      if (depth_q != '0) begin
        depth_d = depth_q - DW'(1'b1);
      end else begin
        depth_d = depth_q;
      end
    end else if (bus.ue && bus.sprw && (int'(bus.reg_sel) < N_SPR)) begin
      case (bus.reg_sel)
        IDX_ESR:  ssr_d[top_s]  = bus.data_in;
        IDX_EPC:  sepc_d[top_s] = bus.data_in;
        IDX_MODE: mode_d        = bus.data_in[0];
        default:  spr_d[bus.reg_sel] = bus.data_in;
      endcase
    end else begin
      depth_d = depth_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NS; i++) begin
        spr_q[i] <= '0;
      end
      for (int i = 0; i < NSLOT; i++) begin
        ssr_q[i]   <= '0;
        sepc_q[i]  <= '0;
        smode_q[i] <= 1'b0;
      end
      mode_q  <= 1'b0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      pend_q  <= '0;
    end else begin
      spr_q   <= spr_d;
      ssr_q   <= ssr_d;
      sepc_q  <= sepc_d;
      smode_q <= smode_d;
      mode_q  <= mode_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.spr_out = rd_s;
  assign bus.jisr    = jisr_s;
  assign bus.il      = il_s;
  assign bus.sr      = spr_q[IDX_SR];
  assign bus.epc     = sepc_q[top_s];
  assign bus.mode    = mode_q;
  assign bus.depth   = depth_q;
  assign bus.stk_ovf = ovf_q;
endmodule

// File: tb/tb_spr_nest.sv
// Directed bench for spr_nest: boot eret, single and nested interrupts,
// stack overflow, repeat-cause epc, masking and asynchronous reset.
module tb_spr_nest;
  localparam int DATA_W  = 32;
  localparam int N_SPR   = 8;
  localparam int N_CAUSE = 23;
  localparam int N_EXT   = 8;
  localparam int DEPTH   = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  spr_nest_if #(.DATA_W(DATA_W), .N_SPR(N_SPR), .N_CAUSE(N_CAUSE),
                .N_EXT(N_EXT), .DEPTH(DEPTH)) bus ();

  spr_nest #(.DATA_W(DATA_W), .N_SPR(N_SPR), .N_CAUSE(N_CAUSE), .N_EXT(N_EXT),
             .DEPTH(DEPTH), .RPT_MASK(23'h000001)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ue      = 1'b0;
    bus.ev_ext  = 8'h00;
    bus.ev_int  = 15'h0000;
    bus.pc      = 32'h0;
    bus.next_pc = 32'h0;
    bus.ea      = 32'h0;
    bus.eret    = 1'b0;
    bus.sprw    = 1'b0;
    bus.reg_sel = 3'd0;
    bus.data_in = 32'h0;
  endtask

  task automatic wr(input logic [2:0] sel, input logic [31:0] d);
    bus.ue = 1'b1; bus.sprw = 1'b1; bus.reg_sel = sel; bus.data_in = d;
    tick();
    idle();
  endtask

  task automatic rd(input logic [2:0] sel, input string tag, input logic [31:0] exp);
    bus.reg_sel = sel;
    #1;
    chk(tag, bus.spr_out, exp);
  endtask

  task automatic do_eret();
    bus.ue = 1'b1; bus.eret = 1'b1;
    tick();
    idle();
  endtask

  task automatic pulse(input logic [7:0] v);
    bus.ev_ext = v;
    tick();
    idle();
  endtask

  task automatic take(input logic [31:0] p);
    bus.ue = 1'b1; bus.pc = p; bus.next_pc = p + 32'h4;
    tick();
    idle();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #12;
    chk("rst_sr", bus.sr, 32'h0);
    chk("rst_epc", bus.epc, 32'h0);
    chk("rst_mode", 32'(bus.mode), 32'h0);
    chk("rst_depth", 32'(bus.depth), 32'h0);
    chk("rst_ovf", 32'(bus.stk_ovf), 32'h0);
    bus.ue = 1'b1; #1;
    chk("rst_jisr", 32'(bus.jisr), 32'h0);
    bus.ue = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick();

    // boot-to-user path at depth 0
    wr(3'd0, 32'h4);   chk("wr_sr", bus.sr, 32'h4);
    wr(3'd3, 32'h100); chk("wr_epc", bus.epc, 32'h100);
    wr(3'd7, 32'h3);   chk("wr_mode", 32'(bus.mode), 32'h1);
    do_eret();
    chk("boot_sr", bus.sr, 32'h0);
    chk("boot_mode", 32'(bus.mode), 32'h0);
    chk("boot_depth", 32'(bus.depth), 32'h0);
    wr(3'd1, 32'h6);   rd(3'd1, "wr_esr", 32'h6);
    do_eret();
    chk("eret_sr6", bus.sr, 32'h6);
    chk("eret_depth0", 32'(bus.depth), 32'h0);

    // sprw together with eret is dropped
    bus.ue = 1'b1; bus.eret = 1'b1; bus.sprw = 1'b1; bus.reg_sel = 3'd6; bus.data_in = 32'h77;
    tick(); idle();
    rd(3'd6, "drop_w_eret", 32'h0);

    // single external interrupt on line 2
    pulse(8'h04);
    bus.ue = 1'b1; bus.pc = 32'h200; bus.next_pc = 32'h204; bus.ea = 32'hDEAD0000; #1;
    chk("irq_jisr", 32'(bus.jisr), 32'h1);
    chk("irq_il", 32'(bus.il), 32'h2);
    tick(); idle();
    chk("irq_depth", 32'(bus.depth), 32'h1);
    chk("irq_epc", bus.epc, 32'h204);
    chk("irq_sr", bus.sr, 32'h0);
    rd(3'd2, "irq_eca", 32'h4);
    rd(3'd4, "irq_edata", 32'hDEAD0000);
    rd(3'd1, "irq_esr", 32'h6);
    bus.ue = 1'b1; #1;
    chk("pend_cleared", 32'(bus.jisr), 32'h0);
    bus.ue = 1'b0;

    // nested interrupt on line 1
    wr(3'd0, 32'h2);
    pulse(8'h02);
    bus.ue = 1'b1; bus.pc = 32'h300; bus.next_pc = 32'h304; #1;
    chk("nest_il", 32'(bus.il), 32'h1);
    tick(); idle();
    chk("nest_depth", 32'(bus.depth), 32'h2);
    chk("nest_epc", bus.epc, 32'h304);
    do_eret();
    chk("nest_ret1_sr", bus.sr, 32'h2);
    chk("nest_ret1_epc", bus.epc, 32'h204);
    do_eret();
    chk("nest_ret2_sr", bus.sr, 32'h6);
    chk("nest_ret2_depth", 32'(bus.depth), 32'h0);

    // overflow: three pushes into a two-entry stack
    wr(3'd7, 32'h1);
    pulse(8'h04); take(32'h400);
    wr(3'd0, 32'h2);
    pulse(8'h02); take(32'h500);
    wr(3'd0, 32'h4);
    pulse(8'h04); take(32'h600);
    chk("ovf_depth", 32'(bus.depth), 32'h2);
    chk("ovf_flag", 32'(bus.stk_ovf), 32'h1);
    chk("ovf_epc", bus.epc, 32'h604);
    do_eret();
    chk("ovf_ret1_sr", bus.sr, 32'h4);
    chk("ovf_ret1_epc", bus.epc, 32'h504);
    do_eret();
    chk("ovf_ret2_sr", bus.sr, 32'h2);
    chk("ovf_ret2_mode", 32'(bus.mode), 32'h0);
    chk("ovf_ret2_depth", 32'(bus.depth), 32'h0);
    chk("ovf_sticky", 32'(bus.stk_ovf), 32'h1);

    // non-maskable cause 0 with repeat epc, concurrent sprw dropped
    wr(3'd5, 32'h11);
    wr(3'd0, 32'h0);
    pulse(8'h01);
    bus.ue = 1'b1; bus.pc = 32'h700; bus.next_pc = 32'h704;
    bus.sprw = 1'b1; bus.reg_sel = 3'd5; bus.data_in = 32'h55; #1;
    chk("nmi_jisr", 32'(bus.jisr), 32'h1);
    chk("nmi_il", 32'(bus.il), 32'h0);
    tick(); idle();
    chk("nmi_epc", bus.epc, 32'h700);
    chk("nmi_depth", 32'(bus.depth), 32'h1);
    rd(3'd5, "nmi_spr5", 32'h11);
    rd(3'd2, "nmi_eca", 32'h1);

    // asynchronous reset mid-handler with a masked line pending
    pulse(8'h08);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_depth", 32'(bus.depth), 32'h0);
    chk("arst_epc", bus.epc, 32'h0);
    chk("arst_ovf", 32'(bus.stk_ovf), 32'h0);
    rd(3'd5, "arst_spr5", 32'h0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    wr(3'd0, 32'h8);
    bus.ue = 1'b1; #1;
    chk("arst_no_pend", 32'(bus.jisr), 32'h0);

    // internal cause 8: masked by sr, then taken, and gated by ue
    bus.ev_int = 15'h0001; #1;
    chk("int_masked", 32'(bus.jisr), 32'h0);
    idle();
    wr(3'd0, 32'h108);
    bus.ue = 1'b1; bus.ev_int = 15'h0001; #1;
    chk("int_jisr", 32'(bus.jisr), 32'h1);
    chk("int_il", 32'(bus.il), 32'h8);
    bus.ue = 1'b0; #1;
    chk("int_no_ue", 32'(bus.jisr), 32'h0);
    idle();

    // line held high across its own clear stays pending
    bus.ev_ext = 8'h08;
    tick();
    bus.ue = 1'b1; bus.next_pc = 32'h804; #1;
    chk("hold_il", 32'(bus.il), 32'h3);
    tick(); idle();
    chk("hold_depth", 32'(bus.depth), 32'h1);
    do_eret();
    chk("hold_ret_sr", bus.sr, 32'h108);
    bus.ue = 1'b1; #1;
    chk("hold_pend_kept", 32'(bus.jisr), 32'h1);
    chk("hold_pend_il", 32'(bus.il), 32'h3);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
